// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encoding and GF(2^8) / inverse-cipher helper functions.
package aes_pkg;

    localparam int unsigned NB = 4;
    localparam int unsigned NK = 4;
    localparam int unsigned NR = 10;

    typedef logic [32*NB-1:0] aes_state_t;
    typedef logic [32*NK-1:0] aes_key_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ADDKEY,
        ROUND,
        LAST,
        DONE
    } fsm_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    // Shift-and-add multiply reduced by x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Byte k sits at [127-8k -: 8] and is row k%4, column k/4; row r rotates right by r.
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round; `last` drops InvMixColumns for the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t keyed;

    always_comb begin
        shifted = inv_shift_rows(state);
        subbed  = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
        end
        keyed      = subbed ^ rk;
        next_state = last ? keyed : inv_mix_columns(keyed);
    end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// AES-128 inverse cipher sequencer: one step per clock, round keys fetched 10 down to 0.
module aes_inv_cipher_ctrl #(
    parameter int unsigned NB  = aes_pkg::NB,
    parameter int unsigned NR  = aes_pkg::NR,
    parameter int unsigned RKW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*NB-1:0] in_data,
    input  logic             ks_valid,
    output logic             rk_rd_en,
    output logic [RKW-1:0]   rk_addr,
    input  logic [32*NB-1:0] rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic             busy,
    output logic [RKW-1:0]   round_idx
);

    import aes_pkg::*;

    localparam int unsigned BW = 32 * NB;

    fsm_e           fsm, fsm_d;
    logic [BW-1:0]  st, st_d, round_out;
    logic           rd_d, ov_d;
    logic [RKW-1:0] addr_d, rnd, rnd_d;

    aes_inv_round u_round (
        .state      (st),
        .rk         (rk_data),
        .last       (fsm == LAST),
        .next_state (round_out)
    );

    assign in_ready  = !rst && (fsm == IDLE) && ks_valid;
    assign out_data  = st;
    assign round_idx = rnd;

    // rk_addr runs one step ahead of rnd so the store's read latency is hidden.
    always_comb begin
        fsm_d  = fsm;
        st_d   = st;
        rd_d   = rk_rd_en;
        addr_d = rk_addr;
        rnd_d  = rnd;
        ov_d   = out_valid;
        unique case (fsm)
            IDLE: begin
                if (in_valid && in_ready) begin
                    st_d   = in_data;
                    addr_d = RKW'(NR);
                    rd_d   = 1'b1;
                    rnd_d  = RKW'(NR);
                    fsm_d  = FETCH;
                end
            end
            FETCH: begin
                addr_d = RKW'(NR - 1);
                fsm_d  = ADDKEY;
            end
            ADDKEY: begin
                st_d   = st ^ rk_data;
                addr_d = RKW'(NR - 2);
                rnd_d  = RKW'(NR - 1);
                fsm_d  = ROUND;
            end
            ROUND: begin
                st_d  = round_out;
                rnd_d = rnd - RKW'(1);
                if (rnd == RKW'(1)) begin
                    addr_d = '0;
                    rd_d   = 1'b0;
                    fsm_d  = LAST;
                end else begin
                    addr_d = rk_addr - RKW'(1);
                end
            end
            LAST: begin
                st_d  = round_out;
                ov_d  = 1'b1;
                fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            st        <= '0;
            rk_rd_en  <= 1'b0;
            rk_addr   <= '0;
            rnd       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fsm       <= fsm_d;
            st        <= st_d;
            rk_rd_en  <= rd_d;
            rk_addr   <= addr_d;
            rnd       <= rnd_d;
            out_valid <= ov_d;
            busy      <= (fsm_d != IDLE);
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: forward-cipher reference model, key-store model and output scoreboard.
module tb_aes_inv_cipher_ctrl;

    localparam int unsigned RKW = 4;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RK10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   in_data = '0;
    logic           ks_valid = 1'b0;
    logic           rk_rd_en;
    logic [RKW-1:0] rk_addr;
    logic [127:0]   rk_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [127:0]   out_data;
    logic           busy;
    logic [RKW-1:0] round_idx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [127:0] exp_q [$];
    logic [3:0]   log_addr [$];
    int           log_cyc [$];
    logic [7:0]   sbox_t [256];
    logic [127:0] rk_mem [11];

    aes_inv_cipher_ctrl #(.NB(4), .NR(10), .RKW(RKW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ks_valid  (ks_valid),
        .rk_rd_en  (rk_rd_en),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rk_rd_en) rk_data <= rk_mem[rk_addr];
    always @(posedge clk) if (rk_rd_en && !rst) begin
        log_addr.push_back(rk_addr);
        log_cyc.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return r;
    endfunction

    // Forward S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < 254; i++) p = mul(p, x);
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0] a0, a1, a2, a3;
        s = pt ^ rk_mem[0];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[127-8*(4*c+rr) -: 8] = t[127-8*(4*((c+rr)%4)+rr) -: 8];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
                    t[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                s = t;
            end
            s = s ^ rk_mem[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer one block; on acceptance push its expected plaintext and return the accept cycle.
    task automatic accept_block(input logic [127:0] pt, output int acc, output bit ok);
        in_data  = encrypt(pt);
        in_valid = 1'b1;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(pt);
                tick();
                acc = cyc;
                ok  = 1'b1;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int oc, output bit ok);
        ok = 1'b0;
        oc = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid) begin
                oc = cyc;
                ok = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ks_valid = 1'b1; in_valid = 1'b0;
        repeat (2) tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        tests++; if (rk_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rk_rd_en: got %b want 0", rk_rd_en); end
        tests++; if (rk_addr !== '0) begin fails++; $display("FAIL rst_rk_addr: got %0d want 0", rk_addr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if (round_idx !== '0) begin fails++; $display("FAIL rst_round_idx: got %0d want 0", round_idx); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_model();
        tests++; if (rk_mem[10] !== RK10) begin fails++; $display("FAIL model_rk10: got %h want %h", rk_mem[10], RK10); end
        tests++; if (encrypt(PT_C1) !== CT_C1) begin fails++; $display("FAIL model_ct: got %h want %h", encrypt(PT_C1), CT_C1); end
    endtask

    task automatic test_c1();
        int acc, oc;
        bit ok, ok2;
        logic [127:0] exp;
        exp_q.delete(); log_addr.delete(); log_cyc.delete();
        out_ready = 1'b1;
        accept_block(PT_C1, acc, ok);
        tests++; if (!ok) begin fails++; $display("FAIL c1_accept: got timeout want accept"); end
        if (ok) begin
            wait_out(oc, ok2);
            tests++; if (!ok2) begin fails++; $display("FAIL c1_out_valid: got timeout want out_valid"); end
            if (ok2) begin
                tests++; if (oc - acc != 12) begin fails++; $display("FAIL c1_latency: got %0d want 12", oc - acc); end
                exp = exp_q.pop_front();
                tests++; if (out_data !== exp) begin fails++; $display("FAIL c1_data: got %h want %h", out_data, exp); end
            end
            tick();
            tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL c1_release: got busy=%b out_valid=%b want 0 0", busy, out_valid);
            end
            tick();
            tests++; if (log_addr.size() != 11) begin fails++; $display("FAIL rk_count: got %0d want 11", log_addr.size()); end
            for (int i = 0; i < 11 && i < log_addr.size(); i++) begin
                tests++;
                if (log_addr[i] !== 4'(10 - i) || log_cyc[i] != acc + i) begin
                    fails++;
                    $display("FAIL rk_trace[%0d]: got addr %0d cycle %0d want addr %0d cycle %0d",
                             i, log_addr[i], log_cyc[i] - acc, 10 - i, i);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int acc, oc;
        bit ok, ok2;
        logic [127:0] pt, held;
        exp_q.delete();
        pt = rand_block();
        out_ready = 1'b0;
        accept_block(pt, acc, ok);
        wait_out(oc, ok2);
        tests++; if (!(ok && ok2)) begin fails++; $display("FAIL bp_out_valid: got timeout want out_valid"); end
        held = (exp_q.size() > 0) ? exp_q.pop_front() : pt;
        tests++; if (out_data !== held) begin fails++; $display("FAIL bp_data: got %h want %h", out_data, held); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got ov=%b in_ready=%b data=%h want 1 0 %h", i, out_valid, in_ready, out_data, held);
            end
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got busy=%b ov=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready);
        end
    endtask

    task automatic test_key_gating();
        int acc, oc;
        bit ok;
        logic [127:0] pt, exp;
        exp_q.delete();
        pt = rand_block();
        ks_valid = 1'b0;
        in_data  = encrypt(pt);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || rk_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL gate_hold[%0d]: got in_ready=%b busy=%b rd=%b want 0 0 0", i, in_ready, busy, rk_rd_en);
            end
        end
        ks_valid = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL gate_ready: got %b want 1", in_ready); end
        exp_q.push_back(pt);
        tick();
        in_valid = 1'b0;
        acc = cyc;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL gate_accept: got busy=%b want 1", busy); end
        wait_out(oc, ok);
        tests++; if (!ok || oc - acc != 12) begin fails++; $display("FAIL gate_latency: got ok=%b lat=%0d want 12", ok, oc - acc); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        tests++; if (out_data !== exp) begin fails++; $display("FAIL gate_data: got %h want %h", out_data, exp); end
        tick();
    endtask

    task automatic test_reset_mid();
        int acc, oc;
        bit ok, found;
        logic [127:0] exp;
        exp_q.delete();
        accept_block(rand_block(), acc, ok);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busy === 1'b1 && round_idx === 4'd5) found = 1'b1;
            else tick();
        end
        tests++; if (!found) begin fails++; $display("FAIL mid_round5: got timeout want round_idx 5"); end
        rst = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL mid_out_data: got %h want 0", out_data); end
        tests++; if (rk_rd_en !== 1'b0) begin fails++; $display("FAIL mid_rk_rd_en: got %b want 0", rk_rd_en); end
        tests++; if (rk_addr !== '0) begin fails++; $display("FAIL mid_rk_addr: got %0d want 0", rk_addr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
        tests++; if (round_idx !== '0) begin fails++; $display("FAIL mid_round_idx: got %0d want 0", round_idx); end
        rst = 1'b0;
        exp_q.delete();
        tick();
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_discard: got ov=%b busy=%b want 0 0", out_valid, busy); end
        accept_block(PT_C1, acc, ok);
        wait_out(oc, ok);
        tests++; if (!ok || oc - acc != 12) begin fails++; $display("FAIL mid_c1_latency: got ok=%b lat=%0d want 12", ok, oc - acc); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        tests++; if (out_data !== exp) begin fails++; $display("FAIL mid_c1_data: got %h want %h", out_data, exp); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [3];
        logic [127:0] exp;
        int acc [3];
        int n_in, n_out;
        bit take;
        exp_q.delete();
        pts[0] = rand_block(); pts[1] = PT_C1; pts[2] = rand_block();
        acc = '{0, 0, 0};
        n_in = 0; n_out = 0;
        out_ready = 1'b1;
        in_data  = encrypt(pts[0]);
        in_valid = 1'b1;
        for (int i = 0; i < 80 && n_out < 3; i++) begin
            #1;
            if (out_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL b2b_unexpected: got %h want no output", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", n_out, out_data, exp); end
                end
                n_out++;
            end
            take = in_valid && in_ready;
            if (take) exp_q.push_back(pts[n_in]);
            tick();
            if (take) begin
                acc[n_in] = cyc;
                n_in++;
                if (n_in < 3) in_data = encrypt(pts[n_in]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests++; if (n_out != 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", n_out); end
        for (int k = 1; k < 3; k++) begin
            tests++;
            if (acc[k] - acc[k-1] != 14) begin fails++; $display("FAIL b2b_period[%0d]: got %0d want 14", k, acc[k] - acc[k-1]); end
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = calc_sbox(8'(i));
        expand_key(KEY_C1);
        test_reset();
        test_model();
        test_c1();
        test_back_pressure();
        test_key_gating();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
